// File: rtl/posit_batch_ctrl.sv
// Batch sequencer: streams operand pairs from mem0, runs them through the posit
// unit with a valid/ready handshake and writes each result into mem1.
module posit_batch_ctrl #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned POSIT_W = 32,
    parameter int unsigned CNT_W   = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   pair_count,
    output logic               completed,
    output logic               busy,
    output logic [ADDR_W-1:0]  mem0_address,
    output logic               mem0_chipselect,
    output logic               mem0_clken,
    output logic               mem0_write,
    output logic [7:0]         mem0_writedata,
    input  logic [7:0]         mem0_readdata,
    output logic [ADDR_W-1:0]  mem1_address,
    output logic               mem1_chipselect,
    output logic               mem1_clken,
    output logic               mem1_write,
    output logic [7:0]         mem1_writedata,
    input  logic [7:0]         mem1_readdata,
    output logic               pu_in_valid,
    input  logic               pu_in_ready,
    output logic [POSIT_W-1:0] pu_num1,
    output logic [POSIT_W-1:0] pu_num2,
    input  logic               pu_out_valid,
    input  logic [POSIT_W-1:0] pu_result
);

    localparam int unsigned Nb        = POSIT_W / 8;
    localparam int unsigned PairBytes = 2 * Nb;
    // One extra step at the end of FETCH collects the last read byte.
    localparam int unsigned StepW     = $clog2(PairBytes + 1);
    localparam logic [CNT_W-1:0] MaxPairs = CNT_W'(512);

    typedef enum logic [2:0] {StIdle, StFetch, StIssue, StWait, StStore, StDone} state_e;

    state_e               state_q, state_d;
    logic [StepW-1:0]     step_q, step_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*POSIT_W-1:0] op_q, op_d;
    logic [POSIT_W-1:0]   res_q, res_d;
    logic                 start_q;
    logic                 armed_q, armed_d;

    logic                 start_rise;
    logic [CNT_W-1:0]     count_clamped;
    logic [CNT_W-1:0]     idx_inc;
    logic [ADDR_W-1:0]    base0, base1;
    logic                 unused_rdata;

    // A batch only starts on a low-to-high start transition seen after start was
    // sampled low at least once since reset, so a start held high through reset
    // cannot launch a batch.
    assign start_rise    = start & ~start_q & armed_q;
    assign count_clamped = (pair_count > MaxPairs) ? MaxPairs : pair_count;
    assign idx_inc       = idx_q + CNT_W'(1);
    assign base0         = ADDR_W'(idx_q) * ADDR_W'(PairBytes);
    assign base1         = ADDR_W'(idx_q) * ADDR_W'(Nb);
    assign unused_rdata  = ^mem1_readdata;

    assign mem0_write     = 1'b0;
    assign mem0_writedata = 8'h00;
    assign pu_num1        = op_q[POSIT_W-1:0];
    assign pu_num2        = op_q[2*POSIT_W-1:POSIT_W];

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            step_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            start_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            res_q   <= res_d;
            start_q <= start;
            armed_q <= armed_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        res_d   = res_q;
        armed_d = armed_q | ~start;
        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    cnt_d   = count_clamped;
                    idx_d   = '0;
                    step_d  = '0;
                    state_d = (count_clamped == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                // Read data lags the address by one cycle; shift bytes in at the
                // top so byte 0 ends up in num1[7:0].
                if (step_q != '0) begin
                    op_d = {mem0_readdata, op_q[2*POSIT_W-1:8]};
                end
                if (step_q == StepW'(PairBytes)) begin
                    step_d  = '0;
                    state_d = StIssue;
                end else begin
                    step_d = step_q + StepW'(1);
                end
            end
            StIssue: begin
                if (pu_in_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (pu_out_valid) begin
                    res_d   = pu_result;
                    step_d  = '0;
                    state_d = StStore;
                end
            end
            StStore: begin
                res_d = res_q >> 8;
                if (step_q == StepW'(Nb - 1)) begin
                    step_d  = '0;
                    idx_d   = idx_inc;
                    state_d = (idx_inc == cnt_q) ? StDone : StFetch;
                end else begin
                    step_d = step_q + StepW'(1);
                end
            end
            StDone: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory strobes, addresses and status outputs decoded from the state.
    always_comb begin
        mem0_address    = '0;
        mem0_chipselect = 1'b0;
        mem0_clken      = 1'b0;
        mem1_address    = '0;
        mem1_chipselect = 1'b0;
        mem1_clken      = 1'b0;
        mem1_write      = 1'b0;
        mem1_writedata  = 8'h00;
        pu_in_valid     = (state_q == StIssue);
        completed       = (state_q == StDone);
        busy            = (state_q == StFetch) || (state_q == StIssue) ||
                          (state_q == StWait)  || (state_q == StStore);
        if ((state_q == StFetch) && (step_q < StepW'(PairBytes))) begin
            mem0_address    = base0 + ADDR_W'(step_q);
            mem0_chipselect = 1'b1;
            mem0_clken      = 1'b1;
        end
        if (state_q == StStore) begin
            mem1_address    = base1 + ADDR_W'(step_q);
            mem1_chipselect = 1'b1;
            mem1_clken      = 1'b1;
            mem1_write      = 1'b1;
            mem1_writedata  = res_q[7:0];
        end
    end

endmodule
